// File: rtl/i2c_regbank_pkg.sv
// i2c_regbank_pkg
// Shared constants for the I2C-style register bank: default parameter
// values and the transaction FSM state encoding.
//   DATA_W_DEF : default register width
//   ADDR_W_DEF : default pointer width (DEPTH = 2**ADDR_W)
//   WRAP_DEF   : default pointer wrap behaviour (1 = wrap, 0 = hold)
//   ST_*       : FSM states IDLE / ADDR / DATA
package i2c_regbank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int WRAP_DEF   = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

endpackage

// File: rtl/i2c_regbank_ptr.sv
// i2c_regbank_ptr
// Register pointer: synchronous load, advance by one, wrap or saturate at
// the last register. Pointer survives idle periods; only reset clears it.
// Ports:
//   i_ck       : clock, rising edge
//   i_rstn     : asynchronous active-low reset
//   i_load     : load pointer from i_load_val (takes priority over advance)
//   i_load_val : new pointer value
//   i_adv      : advance pointer by one
//   o_ptr      : current pointer
module i2c_regbank_ptr
  import i2c_regbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WRAP   = WRAP_DEF
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_ptr
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ptr <= '0;
    end else if (i_load) begin
      o_ptr <= i_load_val;
    end else if (i_adv) begin
      if (o_ptr != PTR_MAX) begin
        o_ptr <= o_ptr + 1'b1;
      end else if (WRAP != 0) begin
        o_ptr <= '0;
      end
      // WRAP == 0: pointer saturates at the last register
    end
  end

endmodule

// File: rtl/i2c_regbank.sv
// i2c_regbank
// Byte-oriented register bank with an I2C-like access protocol: the first
// write after chip select loads the pointer, later writes store data with
// auto-increment, reads return reg[ptr] one cycle later with auto-increment.
// Optional feature macro: I2C_REGBANK_WPROT_EN -- bit0 of the last register
// write-protects all other registers and flags dropped writes on o_wr_err.
// Ports:
//   i_ck     : clock, rising edge
//   i_rstn   : asynchronous active-low reset
//   i_csn    : chip select, 0 = transaction active
//   i_wr_stb : write strobe for i_data (pointer or data byte)
//   i_rd_stb : read strobe
//   i_data   : write data / pointer value
//   o_data   : registered read data, held between reads
//   o_rvalid : one-cycle pulse, o_data updated
//   o_ptr    : current register pointer
//   o_wr_err : one-cycle pulse, data write dropped by write protect
//   o_regs   : all registers flattened, reg[n] at n*DATA_W +: DATA_W
module i2c_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WRAP   = WRAP_DEF
) (
  input  logic                         i_ck,
  input  logic                         i_rstn,
  input  logic                         i_csn,
  input  logic                         i_wr_stb,
  input  logic                         i_rd_stb,
  input  logic [DATA_W-1:0]            i_data,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_rvalid,
  output logic [ADDR_W-1:0]            o_ptr,
  output logic                         o_wr_err,
  output logic [(2**ADDR_W)*DATA_W-1:0] o_regs
);

  localparam int DEPTH = 2**ADDR_W;

  state_t            state;
  logic              in_txn;
  logic              wr;
  logic              rd;
  logic              ptr_load;
  logic              data_wr;
  logic              wr_block;
  logic              wr_commit;
  logic              ptr_adv;
  logic [DATA_W-1:0] rd_word;

  // Strobes only count once the FSM has left IDLE and chip select is still
  // asserted in the same cycle. A write wins over a simultaneous read.
  assign in_txn    = !i_csn && (state != ST_IDLE);
  assign wr        = in_txn && i_wr_stb;
  assign rd        = in_txn && i_rd_stb && !i_wr_stb;
  assign ptr_load  = wr && (state == ST_ADDR);
  assign data_wr   = wr && (state == ST_DATA);
  assign wr_commit = data_wr && !wr_block;
  // A blocked write still consumes its address slot.
  assign ptr_adv   = data_wr || rd;
  assign rd_word   = o_regs[o_ptr*DATA_W +: DATA_W];

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else if (i_csn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ADDR;
        ST_ADDR: if (i_wr_stb) state <= ST_DATA;
        ST_DATA: state <= ST_DATA;
        default: state <= ST_IDLE;
      endcase
    end
  end

  i2c_regbank_ptr #(
    .ADDR_W (ADDR_W),
    .WRAP   (WRAP)
  ) u_ptr (
    .i_ck       (i_ck),
    .i_rstn     (i_rstn),
    .i_load     (ptr_load),
    .i_load_val (i_data[ADDR_W-1:0]),
    .i_adv      (ptr_adv),
    .o_ptr      (o_ptr)
  );

  // Register storage: one flop word per address, exposed directly on o_regs.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [DATA_W-1:0] r;
    always_ff @(posedge i_ck or negedge i_rstn) begin
      if (!i_rstn) begin
        r <= '0;
      end else if (wr_commit && (o_ptr == ADDR_W'(gi))) begin
        r <= i_data;
      end
    end
    assign o_regs[gi*DATA_W +: DATA_W] = r;
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      o_data   <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= rd;
      if (rd) begin
        o_data <= rd_word;
      end
    end
  end

`ifdef I2C_REGBANK_WPROT_EN
  // The protect register itself stays writable so protection can be lifted.
  assign wr_block = o_regs[(DEPTH-1)*DATA_W] && (o_ptr != ADDR_W'(DEPTH-1));

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= data_wr && wr_block;
    end
  end
`else
  assign wr_block = 1'b0;
  assign o_wr_err = 1'b0;
`endif

endmodule

// File: doc/i2c_regbank.md
I2C_REGBANK -- requirements
Module: i2c_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, pointer width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter WRAP, default 1, pointer wraps DEPTH-1->0 when 1, holds at DEPTH-1 when 0.
REQ-004 SHALL have port i_ck  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_csn  input  1  chip select, 0 = transaction active.
REQ-007 SHALL have port i_wr_stb  input  1  one-cycle write strobe for byte on i_data.
REQ-008 SHALL have port i_rd_stb  input  1  one-cycle read strobe.
REQ-009 SHALL have port i_data  input  DATA_W  write data or pointer value.
REQ-010 SHALL have port o_data  output  DATA_W  registered read data.
REQ-011 SHALL have port o_rvalid  output  1  one-cycle pulse, o_data valid.
REQ-012 SHALL have port o_ptr  output  ADDR_W  current register pointer.
REQ-013 SHALL have port o_wr_err  output  1  one-cycle pulse, write dropped.
REQ-014 SHALL have port o_regs  output  DEPTH*DATA_W  all registers flattened, reg[n] at bits n*DATA_W +: DATA_W.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-016 SHALL go IDLE->ADDR on edge with i_csn=0; any state ->IDLE on edge with i_csn=1.
REQ-017 SHALL in ADDR, on i_wr_stb, load pointer with i_data[ADDR_W-1:0] (upper bits ignored), no register write, go to DATA.
REQ-018 SHALL in DATA, on i_wr_stb, write i_data to reg[ptr] and advance pointer.
REQ-019 SHALL in ADDR or DATA, on i_rd_stb, register reg[ptr] into o_data, pulse o_rvalid next cycle (latency 1), advance pointer; state unchanged.
REQ-020 SHALL advance pointer by 1; at DEPTH-1, go to 0 if WRAP=1, else hold.
REQ-021 SHALL, with i_wr_stb and i_rd_stb both high, execute write only; read ignored, no o_rvalid.
REQ-022 SHALL ignore strobes in IDLE and strobes in the cycle i_csn is 1.
REQ-023 SHALL retain pointer across IDLE (current-address read support).
REQ-024 SHALL hold o_data between reads; o_rvalid low otherwise.
REQ-025 SHALL update o_regs the cycle after a write.

Reset
REQ-026 SHALL on i_rstn=0 immediately clear all registers, pointer, o_data, o_rvalid, o_wr_err to 0 and FSM to IDLE, including mid-transaction.
REQ-027 SHALL, after reset release with i_csn=0, enter ADDR on next edge.

Configuration
REQ-028 SHALL with I2C_REGBANK_WPROT_EN defined treat reg[DEPTH-1] bit0 as write-protect: when 1, data writes to addresses 0..DEPTH-2 are dropped, pulse o_wr_err, pointer still advances; reg[DEPTH-1] always writable.
REQ-029 SHALL without I2C_REGBANK_WPROT_EN treat all registers as plain storage and tie o_wr_err to 0.

Structure
REQ-030 SHALL place FSM state encoding and default parameter constants in package i2c_regbank_pkg.
REQ-031 SHALL implement pointer load/advance/wrap in sub-module i2c_regbank_ptr.

Verification
REQ-032 SHALL verify burst write: csn=0, wr 0x02, wr 0xA1, 0xB2, 0xC3 -> reg2=A1, reg3=B2, reg4=C3, o_ptr=5.
REQ-033 SHALL verify current-address read: after REQ-032, csn=1 then 0, rd x2 -> o_data 0x00 (reg5), 0x00 (reg6) each with o_rvalid one cycle after strobe; then address 0x02 + rd -> 0xA1.
REQ-034 SHALL verify wrap: ptr=0x0F, wr 0x11, 0x22 -> reg15=11, reg0=22 (WRAP=1); WRAP=0 -> reg15=22, ptr stays 0x0F.
REQ-035 SHALL verify simultaneous wr+rd in DATA at ptr 3, data 0x5A -> reg3=5A, no o_rvalid, ptr=4.
REQ-036 SHALL verify reset mid-burst: after 2 writes assert i_rstn=0 -> o_regs=0, o_ptr=0, FSM IDLE without clock edge.
REQ-037 SHALL verify with I2C_REGBANK_WPROT_EN: reg15=0x01, write 0x77 to reg1 -> reg1 unchanged, o_wr_err one pulse; write reg15=0x00 accepted.
